// File: rtl/wb_trace_buffer_if.sv
// Read channel of the writeback trace buffer.
//   rd_valid : head record available (buffer -> consumer)
//   rd_ready : consumer accepts the head record (consumer -> buffer)
//   rd_reg   : head record destination register
//   rd_data  : head record write data
//   rd_pc    : head record fetch PC
// The master modport is the trace buffer side; the slave modport is the consumer.
interface wb_trace_buffer_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_reg;
    logic [31:0] rd_data;
    logic [11:0] rd_pc;

    modport master (
        output rd_valid,
        output rd_reg,
        output rd_data,
        output rd_pc,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_reg,
        input  rd_data,
        input  rd_pc,
        output rd_ready
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer.
// Snoops register-file writes (ctrl_writeEnable/ctrl_writeReg/data_writeReg) together with
// the PC of the writing instruction and queues them as trace records in a FIFO. A debug
// consumer drains the records over the valid/ready read channel.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   arm, clear          : 1-cycle control pulses (start capture / flush and go idle)
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg, pc : snooped writeback
//   rd                  : read channel (wb_trace_buffer_if.master)
//   count               : FIFO occupancy, 0..DEPTH
//   dropped             : saturating count of records lost while full or frozen
//   overflow            : sticky, set once any record has been lost
//   state               : 0 IDLE, 1 CAPTURE, 2 FROZEN
module wb_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter bit STOP_ON_FULL = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              clear,
    input  logic              ctrl_writeEnable,
    input  logic [4:0]        ctrl_writeReg,
    input  logic [31:0]       data_writeReg,
    input  logic [11:0]       pc,
    wb_trace_buffer_if.master rd,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       dropped,
    output logic              overflow,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    localparam int              REC_W      = 5 + 32 + 12;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // Record storage; no reset so it maps onto block RAM.
    logic [REC_W-1:0] mem [DEPTH];

    state_t            state_reg;
    logic [ADDR_W-1:0] head_reg;
    logic [ADDR_W-1:0] tail_reg;
    logic [ADDR_W:0]   count_reg;
    logic [15:0]       dropped_reg;
    logic              overflow_reg;
    logic              rd_valid_reg;
    logic [REC_W-1:0]  rd_rec_reg;

    logic              cap_event;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [ADDR_W-1:0] head_next;
    logic [ADDR_W:0]   count_after_pop;
    logic [REC_W-1:0]  wr_rec;

    always_comb begin
        // r0 writes are architecturally invisible, so they never form a record.
        cap_event       = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        full            = (count_reg == FULL_COUNT);
        pop             = rd_valid_reg && rd.rd_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
        push            = cap_event && (state_reg == ST_CAPTURE) && (!full || pop);
        drop            = cap_event && (((state_reg == ST_CAPTURE) && full && !pop) ||
                                        (state_reg == ST_FROZEN));
        head_next       = pop ? head_reg + 1'b1 : head_reg;
        count_after_pop = count_reg - {{ADDR_W{1'b0}}, pop};
        wr_rec          = {ctrl_writeReg, data_writeReg, pc};
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail_reg] <= wr_rec;
        end
    end

    // Registered head record. When the FIFO is (about to be) empty the incoming record
    // bypasses the RAM so it is visible one cycle after capture.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_valid_reg <= 1'b0;
            rd_rec_reg   <= '0;
        end else begin
            rd_valid_reg <= (count_after_pop != '0) || push;
            if (push && (count_after_pop == '0)) begin
                rd_rec_reg <= wr_rec;
            end else begin
                rd_rec_reg <= mem[head_next];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_reg    <= ST_IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            dropped_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg  <= head_next;
            count_reg <= count_after_pop + {{ADDR_W{1'b0}}, push};
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                if (dropped_reg != 16'hFFFF) begin
                    dropped_reg <= dropped_reg + 16'd1;
                end
            end
            case (state_reg)
                ST_IDLE: begin
                    if (arm) begin
                        state_reg <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (drop && STOP_ON_FULL) begin
                        state_reg <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    // Re-arming resumes capture with the buffered records kept.
                    if (arm) begin
                        state_reg <= ST_CAPTURE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rd.rd_valid = rd_valid_reg;
    assign rd.rd_reg   = rd_rec_reg[REC_W-1 -: 5];
    assign rd.rd_data  = rd_rec_reg[43:12];
    assign rd.rd_pc    = rd_rec_reg[11:0];
    assign count       = count_reg;
    assign dropped     = dropped_reg;
    assign overflow    = overflow_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm   = 1'b0;
    logic        clear = 1'b0;
    logic        we    = 1'b0;
    logic [4:0]  wreg  = '0;
    logic [31:0] wdata = '0;
    logic [11:0] wpc   = '0;
    logic [4:0]  count;
    logic [15:0] dropped;
    logic        overflow;
    logic [1:0]  state;

    wb_trace_buffer_if rd_bus ();

    wb_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STOP_ON_FULL(1'b1)) dut (
        .clock            (clock),
        .reset            (reset),
        .arm              (arm),
        .clear            (clear),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wreg),
        .data_writeReg    (wdata),
        .pc               (wpc),
        .rd               (rd_bus.master),
        .count            (count),
        .dropped          (dropped),
        .overflow         (overflow),
        .state            (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic [11:0] p;
    } rec_t;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   seq    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic [11:0] p,
                      input bit accept);
        we    = 1'b1;
        wreg  = r;
        wdata = d;
        wpc   = p;
        if (accept) sb.push_back('{r, d, p});
        tick();
        we = 1'b0;
    endtask

    // Write with a fresh non-zero register, random data and a sequential PC.
    task automatic wr_next(input bit accept);
        logic [4:0] r;
        r = 5'((seq % 31) + 1);
        wr(r, $urandom, 12'(seq * 4), accept);
        seq++;
    endtask

    task automatic drain(input int max_cycles);
        rd_bus.rd_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (count == 5'd0) break;
            tick();
        end
        rd_bus.rd_ready = 1'b0;
        tick();
        check("drain_count", count, 5'd0);
        check("drain_sb_empty", sb.size(), 0);
    endtask

    // Fill, lose one record (freezes), then pop 9 leaving 7 queued.
    task automatic fill_to_seven();
        pulse_arm();
        for (int i = 0; i < 17; i++) wr_next(i < 16);
        rd_bus.rd_ready = 1'b1;
        repeat (9) tick();
        rd_bus.rd_ready = 1'b0;
        check("fill7_count", count, 5'd7);
        check("fill7_dropped", dropped, 16'd1);
        check("fill7_overflow", overflow, 1'b1);
    endtask

    // Scoreboard: every accepted record is compared when the consumer takes it.
    always @(negedge clock) begin
        if (!reset && rd_bus.rd_valid && rd_bus.rd_ready) begin
            rec_t exp;
            check("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                $display("pop reg=%0d data=%08h pc=%03h", rd_bus.rd_reg, rd_bus.rd_data,
                         rd_bus.rd_pc);
                check("pop_reg", rd_bus.rd_reg, exp.r);
                check("pop_data", rd_bus.rd_data, exp.d);
                check("pop_pc", rd_bus.rd_pc, exp.p);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_bus.rd_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_count", count, 5'd0);
        check("rst_valid", rd_bus.rd_valid, 1'b0);
        check("rst_state", state, 2'd0);
        check("rst_dropped", dropped, 16'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_rd_data", rd_bus.rd_data, 32'd0);

        // 1: single record, one-cycle capture-to-valid latency, then pop
        pulse_arm();
        check("t1_state", state, 2'd1);
        wr(5'd3, 32'h0000_0005, 12'h010, 1'b1);
        check("t1_valid", rd_bus.rd_valid, 1'b1);
        check("t1_reg", rd_bus.rd_reg, 5'd3);
        check("t1_data", rd_bus.rd_data, 32'h5);
        check("t1_pc", rd_bus.rd_pc, 12'h010);
        check("t1_count", count, 5'd1);
        rd_bus.rd_ready = 1'b1;
        tick();
        rd_bus.rd_ready = 1'b0;
        check("t1_valid_after_pop", rd_bus.rd_valid, 1'b0);
        check("t1_count_after_pop", count, 5'd0);

        // 2: r0 writes and writes while idle are ignored, not dropped
        wr(5'd0, 32'hDEAD_BEEF, 12'h020, 1'b0);
        pulse_clear();
        wr(5'd5, 32'h1234_5678, 12'h024, 1'b0);
        check("t2_count", count, 5'd0);
        check("t2_dropped", dropped, 16'd0);
        check("t2_valid", rd_bus.rd_valid, 1'b0);

        // 3: 18 writes with no consumer -> 16 kept, 2 dropped, frozen
        pulse_arm();
        for (int i = 0; i < 18; i++) wr_next(i < 16);
        check("t3_count", count, 5'd16);
        check("t3_state", state, 2'd2);
        check("t3_dropped", dropped, 16'd2);
        check("t3_overflow", overflow, 1'b1);
        drain(40);

        // 4: full FIFO, pop and write in the same cycle -> write accepted
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < 16; i++) wr_next(1'b1);
        check("t4_full_count", count, 5'd16);
        rd_bus.rd_ready = 1'b1;
        wr_next(1'b1);
        rd_bus.rd_ready = 1'b0;
        check("t4_count", count, 5'd16);
        check("t4_dropped", dropped, 16'd0);
        check("t4_state", state, 2'd1);
        drain(40);

        // 5: 40 writes with continuous consumer -> pointers wrap, nothing lost
        pulse_clear();
        pulse_arm();
        rd_bus.rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) wr_next(1'b1);
        drain(10);
        check("t5_dropped", dropped, 16'd0);
        check("t5_overflow", overflow, 1'b0);

        // 6a: clear with 7 records queued
        pulse_clear();
        fill_to_seven();
        pulse_clear();
        check("t6c_count", count, 5'd0);
        check("t6c_valid", rd_bus.rd_valid, 1'b0);
        check("t6c_state", state, 2'd0);
        check("t6c_dropped", dropped, 16'd0);
        check("t6c_overflow", overflow, 1'b0);

        // 6b: reset with 7 records queued
        fill_to_seven();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("t6r_count", count, 5'd0);
        check("t6r_valid", rd_bus.rd_valid, 1'b0);
        check("t6r_state", state, 2'd0);
        check("t6r_dropped", dropped, 16'd0);
        check("t6r_overflow", overflow, 1'b0);
        check("t6r_rd_reg", rd_bus.rd_reg, 5'd0);
        check("t6r_rd_pc", rd_bus.rd_pc, 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
